// File: rtl/caliptra_prim_sync_reqack_arb.sv
// Round-robin arbiter sharing the SRC side of one REQ/ACK-with-data CDC synchronizer.
// Data presented to the synchronizer changes only in the LOAD cycle, while src_req_o is low.

module caliptra_prim_sync_reqack_arb_chk #(
    parameter int NumReq = 4,
    parameter int Width  = 32
) (
    input logic              clk_i,
    input logic              rst_i,
    input logic [NumReq-1:0] ack_i,
    input logic              src_req_i,
    input logic [Width-1:0]  src_data_i
);
    a_data_only_when_req_low : assert property (@(posedge clk_i) disable iff (rst_i)
        !$stable(src_data_i) |-> !src_req_i);

    a_ack_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(ack_i));

    a_req_rise_data_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        $rose(src_req_i) |-> $stable(src_data_i));
endmodule

module caliptra_prim_sync_reqack_arb #(
    parameter int  NumReq        = 4,
    parameter int  Width         = 32,
    parameter int  TimeoutCycles = 0,
    localparam int IdxW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumReq-1:0]       req_i,
    input  logic [NumReq*Width-1:0] data_i,
    output logic [NumReq-1:0]       ack_o,
    output logic                    src_req_o,
    input  logic                    src_ack_i,
    output logic [Width-1:0]        src_data_o,
    output logic [IdxW-1:0]         gnt_idx_o,
    output logic                    busy_o,
    output logic                    timeout_o
);
    localparam bit                TmoEn    = (TimeoutCycles > 0);
    localparam int                CntW     = TmoEn ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0]   CntMax   = CntW'(TimeoutCycles);
    localparam logic [NumReq-1:0] ReqLsb   = NumReq'(1'b1);
    localparam logic [IdxW-1:0]   LastInit = IdxW'(NumReq - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StWait = 2'd2
    } state_e;

    state_e            state_q;
    logic              src_req_q;
    logic              busy_q;
    logic              timeout_q;
    logic [Width-1:0]  src_data_q;
    logic [IdxW-1:0]   gnt_idx_q;
    logic [IdxW-1:0]   last_q;
    logic [CntW-1:0]   cnt_q;
    logic [CntW-1:0]   cnt_d;
    logic [NumReq-1:0] req_cand_s;
    logic [NumReq-1:0] req_rot_s;
    logic              pick_vld_s;
    logic [IdxW-1:0]   pick_idx_s;
    logic [Width-1:0]  pick_data_s;
    logic [NumReq-1:0] ack_s;

    // Round-robin pick starting after last_q; while waiting, the current grant is excluded.
    always_comb begin
        req_cand_s = req_i;
        req_rot_s  = '0;
        pick_vld_s = 1'b0;
        pick_idx_s = '0;
        if (state_q == StWait) begin
            req_cand_s = req_i & ~(ReqLsb << gnt_idx_q);
        end else begin
            req_cand_s = req_i;
        end
        // Walk from farthest to nearest so the nearest set bit wins.
        for (int i = NumReq; i > 0; i--) begin
            req_rot_s = req_cand_s >> ((int'(last_q) + i) % NumReq);
            if (req_rot_s[0]) begin
                pick_vld_s = 1'b1;
                pick_idx_s = IdxW'((int'(last_q) + i) % NumReq);
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Select the data slice of the picked requester.
    always_comb begin
        pick_data_s = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (pick_idx_s == IdxW'(k)) begin
                pick_data_s = data_i[k*Width +: Width];
            end else begin
                pick_data_s = pick_data_s;
            end
        end
    end

    // Ack pulse to the granted requester and saturating stall counter increment.
    always_comb begin
        ack_s = '0;
        cnt_d = cnt_q;
        if ((state_q == StWait) && src_ack_i) begin
            ack_s = ReqLsb << gnt_idx_q;
        end else begin
            ack_s = '0;
        end
        if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CntW'(1'b1);
        end
    end

    // Transfer sequencing FSM with registered synchronizer-side outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            src_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            src_data_q <= '0;
            gnt_idx_q  <= '0;
            last_q     <= LastInit;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pick_vld_s) begin
                        state_q    <= StLoad;
                        busy_q     <= 1'b1;
                        src_data_q <= pick_data_s;
                        gnt_idx_q  <= pick_idx_s;
                        last_q     <= pick_idx_s;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StLoad: begin
                    state_q   <= StWait;
                    src_req_q <= 1'b1;
                    cnt_q     <= '0;
                    timeout_q <= 1'b0;
                end
                StWait: begin
                    if (src_ack_i) begin
                        src_req_q <= 1'b0;
                        timeout_q <= 1'b0;
                        cnt_q     <= '0;
                        if (pick_vld_s) begin
                            state_q    <= StLoad;
                            src_data_q <= pick_data_s;
                            gnt_idx_q  <= pick_idx_s;
                            last_q     <= pick_idx_s;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else if (TmoEn) begin
                        cnt_q     <= cnt_d;
                        timeout_q <= (cnt_d == CntMax);
                    end else begin
                        timeout_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    src_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign ack_o      = ack_s;
    assign src_req_o  = src_req_q;
    assign src_data_o = src_data_q;
    assign gnt_idx_o  = (NumReq > 1) ? gnt_idx_q : '0;
    assign busy_o     = busy_q;
    assign timeout_o  = timeout_q;

    caliptra_prim_sync_reqack_arb_chk #(
        .NumReq (NumReq),
        .Width  (Width)
    ) u_chk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ack_i      (ack_o),
        .src_req_i  (src_req_o),
        .src_data_i (src_data_o)
    );
endmodule

// File: tb/tb_caliptra_prim_sync_reqack_arb.sv
// Self-checking bench: directed table, hand sequences and random stimulus against a reference model.
module tb_caliptra_prim_sync_reqack_arb;
    localparam int N = 4;
    localparam int W = 32;
    localparam int T = 8;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [N-1:0]   req_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   ack_o;
    logic           src_req_o;
    logic           src_ack_i;
    logic [W-1:0]   src_data_o;
    logic [1:0]     gnt_idx_o;
    logic           busy_o;
    logic           timeout_o;

    caliptra_prim_sync_reqack_arb #(.NumReq(N), .Width(W), .TimeoutCycles(T)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .data_i     (data_i),
        .ack_o      (ack_o),
        .src_req_o  (src_req_o),
        .src_ack_i  (src_ack_i),
        .src_data_o (src_data_o),
        .gnt_idx_o  (gnt_idx_o),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 idle, 1 load, 2 waiting for ack; m_k counts waiting cycles.
    int          m_phase, m_ptr, m_gnt, m_k;
    logic [31:0] m_data;

    logic        obs_src_req, obs_busy, obs_tmo;
    logic [3:0]  obs_ack;
    logic [1:0]  obs_gnt;
    logic [31:0] obs_data;

    typedef struct {
        logic [3:0]  req;
        logic        ack;
        logic        e_src_req;
        logic [3:0]  e_ack;
        logic [1:0]  e_gnt;
        logic        e_busy;
        logic [31:0] e_data;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [3:0] rq, input int ptr, input int excl);
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (ptr + i) % N;
            if (rq[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ptr = N - 1; m_gnt = 0; m_k = 0; m_data = 32'h0;
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic step(input logic r, input logic [3:0] rq, input logic a);
        logic [3:0] e_ack;
        int c;
        rst_i = r; req_i = rq; src_ack_i = a;
        #2;
        obs_src_req = src_req_o; obs_busy = busy_o; obs_tmo = timeout_o;
        obs_ack = ack_o; obs_gnt = gnt_idx_o; obs_data = src_data_o;
        e_ack = (m_phase == 2 && a) ? 4'(1 << m_gnt) : 4'b0;
        chk("src_req", 32'(obs_src_req), 32'(m_phase == 2));
        chk("busy", 32'(obs_busy), 32'(m_phase != 0));
        chk("ack", 32'(obs_ack), 32'(e_ack));
        chk("gnt_idx", 32'(obs_gnt), 32'(m_gnt));
        chk("src_data", obs_data, m_data);
        chk("timeout", 32'(obs_tmo), 32'(m_phase == 2 && m_k > T));
        if (r) begin
            model_reset();
        end else if (m_phase == 0) begin
            c = rr(rq, m_ptr, -1);
            if (c >= 0) begin
                m_phase = 1; m_gnt = c; m_ptr = c; m_data = data_i[c*W +: W];
            end
        end else if (m_phase == 1) begin
            m_phase = 2; m_k = 1;
        end else if (a) begin
            c = rr(rq, m_ptr, m_gnt);
            if (c >= 0) begin
                m_phase = 1; m_gnt = c; m_ptr = c; m_data = data_i[c*W +: W];
            end else begin
                m_phase = 0;
            end
        end else begin
            m_k++;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (!busy_o) break;
            step(1'b0, 4'b0000, src_req_o);
        end
        chk("drain_idle", 32'(busy_o), 32'(0));
    endtask

    initial begin
        int order[5];
        int nord, wcnt, loads, first_tmo, wk;
        logic a, r;

        for (int k = 0; k < N; k++) data_i[k*W +: W] = 32'hA5A5_0000 + 32'(k);
        tbl[0] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 32'h0};
        tbl[1] = '{4'b0100, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1, 32'hA5A5_0002};
        tbl[2] = '{4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1, 32'hA5A5_0002};
        tbl[3] = '{4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1, 32'hA5A5_0002};
        tbl[4] = '{4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1, 32'hA5A5_0002};
        tbl[5] = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 32'hA5A5_0002};
        tbl[6] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 32'hA5A5_0002};
        tbl[7] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 32'hA5A5_0002};

        rst_i = 1'b1; req_i = 4'b0; src_ack_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        model_reset();
        chk("reset_timeout", 32'(timeout_o), 32'(0));

        // Single request table
        for (int i = 0; i < 8; i++) begin
            step(1'b0, tbl[i].req, tbl[i].ack);
            chk("tbl_src_req", 32'(obs_src_req), 32'(tbl[i].e_src_req));
            chk("tbl_ack", 32'(obs_ack), 32'(tbl[i].e_ack));
            chk("tbl_gnt", 32'(obs_gnt), 32'(tbl[i].e_gnt));
            chk("tbl_busy", 32'(obs_busy), 32'(tbl[i].e_busy));
            chk("tbl_data", obs_data, tbl[i].e_data);
        end

        // Timeout with ack withheld
        first_tmo = -1; wk = 0;
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 4'b0001, 1'b0);
            if (obs_src_req) wk++;
            if (obs_tmo && first_tmo < 0) first_tmo = wk;
        end
        chk("tmo_first_wait_cycle", 32'(first_tmo), 32'(T + 1));
        chk("tmo_src_req_held", 32'(src_req_o), 32'(1));
        step(1'b0, 4'b0000, 1'b1);
        chk("tmo_ack", 32'(obs_ack), 32'(4'b0001));
        chk("tmo_cleared", 32'(timeout_o), 32'(0));
        drain();

        // Reset in the middle of WAIT
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0001, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        chk("rst_src_req", 32'(src_req_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_data", src_data_o, 32'h0);
        step(1'b0, 4'b1000, 1'b0);
        chk("rst_no_ack", 32'(obs_ack), 32'(0));
        step(1'b0, 4'b1000, 1'b0);
        chk("rst_then_gnt3", 32'(obs_gnt), 32'(3));
        drain();

        // Round robin with all requesters held
        nord = 0; wcnt = 0; loads = 0;
        for (int i = 0; i < 5; i++) order[i] = -1;
        for (int i = 0; i < 80; i++) begin
            if (nord >= 5) break;
            wcnt = src_req_o ? wcnt + 1 : 0;
            if (busy_o && !src_req_o) loads++;
            a = (wcnt == 4);
            if (a) begin
                order[nord] = 32'(gnt_idx_o);
                nord++;
            end
            step(1'b0, 4'b1111, a);
        end
        for (int i = 0; i < 5; i++) chk("rr_order", 32'(order[i]), 32'(i % 4));
        chk("rr_load_cycles", 32'(loads), 32'(5));
        drain();

        // Back-to-back without an IDLE cycle
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b0011, 1'b0);
        step(1'b0, 4'b0011, 1'b0);
        step(1'b0, 4'b0011, 1'b1);
        chk("b2b_first_gnt", 32'(obs_gnt), 32'(0));
        chk("b2b_busy", 32'(busy_o), 32'(1));
        chk("b2b_load_req_low", 32'(src_req_o), 32'(0));
        chk("b2b_next_gnt", 32'(gnt_idx_o), 32'(1));
        chk("b2b_next_data", src_data_o, 32'hA5A5_0001);
        drain();

        // Spurious acks in IDLE and LOAD
        step(1'b0, 4'b0000, 1'b1);
        chk("spur_idle_ack", 32'(obs_ack), 32'(0));
        step(1'b0, 4'b0010, 1'b1);
        step(1'b0, 4'b0010, 1'b1);
        chk("spur_load_ack", 32'(obs_ack), 32'(0));
        chk("spur_load_busy", 32'(obs_busy), 32'(1));
        step(1'b0, 4'b0010, 1'b0);
        chk("spur_wait_req", 32'(obs_src_req), 32'(1));
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) data_i[k*W +: W] = $urandom;
            r = ($urandom_range(0, 99) == 0);
            a = !r && ($urandom_range(0, 3) == 0);
            step(r, 4'($urandom), a);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/caliptra_prim_sync_reqack_arb.md
Name: caliptra_prim_sync_reqack_arb

Overview:
- Round-robin arbiter that shares the SRC side of one REQ/ACK-with-data CDC synchronizer between NumReq requesters in the SRC clock domain.
- Sequences every transfer so the data presented to the synchronizer is updated only while its REQ is low, and stays stable until ACK is returned.
- Returns a one-cycle ack to the granted requester.
- Flags handshakes that stall longer than a programmable bound.

Parameters:
- NumReq, 4: number of requesters, ≥1.
- Width, 32: data width per requester.
- TimeoutCycles, 0: WAIT-state cycle bound before timeout_o asserts; 0 disables the timeout.

Ports:
- clk_i  in  1  SRC-domain clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  NumReq  per-requester request, level.
- data_i  in  NumReq*Width  per-requester data; slice k = [k*Width +: Width].
- ack_o  out  NumReq  one-hot, one-cycle transfer-complete pulse.
- src_req_o  out  1  to synchronizer src_req_i.
- src_ack_i  in  1  from synchronizer src_ack_o; one-cycle pulse.
- src_data_o  out  Width  to synchronizer data_i; registered.
- gnt_idx_o  out  IdxW  index of the current grant. IdxW = NumReq>1 ? $clog2(NumReq) : 1.
- busy_o  out  1  high in LOAD or WAIT.
- timeout_o  out  1  handshake stall indicator.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - state=IDLE.
  - src_req_o=0, src_data_o=0, ack_o=0, gnt_idx_o=0, busy_o=0, timeout_o=0.
  - RR pointer last_q=NumReq-1, so requester 0 has first priority.
  - Timeout counter=0.
- FSM states: IDLE, LOAD, WAIT.
- IDLE:
  - If any req_i is set, grant the first set bit scanning last_q+1, last_q+2, … modulo NumReq.
  - At the edge: latch the granted data slice into src_data_o, the index into gnt_idx_o and last_q; go to LOAD.
  - Otherwise remain in IDLE.
- LOAD:
  - src_req_o=0 while src_data_o has just changed.
  - Unconditionally go to WAIT.
- WAIT:
  - src_req_o=1; src_data_o and gnt_idx_o held constant.
  - When src_ack_i=1: ack_o[gnt_idx_o]=1 combinationally in the same cycle.
    - If any req_i bit other than the current grant is set, arbitrate (same RR rule, current grant excluded) and go to LOAD with new data latched.
    - Otherwise go to IDLE.
    - src_req_o is 0 the following cycle in either case.
- src_ack_i outside WAIT is ignored; ack_o stays 0.
- Latency:
  - req_i rising in IDLE at cycle 0 → src_req_o=1 from cycle 2.
  - ack_o pulses in the cycle src_ack_i=1.
- Minimum spacing between successive src_req_o assertions is one low cycle (the LOAD cycle).
- Requester rules:
  - Hold req_i until ack_o.
  - data_i is sampled only at grant.
  - Dropping req_i after grant does not cancel the transfer; ack_o still pulses.
  - A requester still asserting req_i after its ack_o is rearbitrated normally.
- Timeout, only when TimeoutCycles>0:
  - Counter is cleared on entering WAIT and increments each WAIT cycle, saturating at TimeoutCycles.
  - timeout_o=1 while in WAIT with counter==TimeoutCycles; cleared on the ack cycle's exit.
  - The transfer is never aborted, because aborting would desynchronize the NRZ handshake.
- NumReq=1: arbitration is trivial and gnt_idx_o is tied to 0.
- Reset mid-transfer: returns to IDLE immediately with no ack_o. The synchronizer's SRC and DST resets must be asserted together with rst_i. This is an integration requirement.
- Assertions:
  - src_data_o changes only when src_req_o=0.
  - ack_o is one-hot0.
  - src_req_o never rises in the same cycle src_data_o changes.

Test Plan:
- Single request: req_i=4'b0100, data slice 2=32'hA5A5_0002 at cycle 0 → src_req_o=1 at cycle 2 with src_data_o=32'hA5A5_0002 and gnt_idx_o=2. Ack at cycle 5 → ack_o=4'b0100 at cycle 5; src_req_o=0 at cycle 6; back in IDLE.
- Round robin: req_i=4'b1111 held, ack returned 3 cycles after each src_req_o rise → grant order 0,1,2,3,0. Each transfer has one LOAD cycle with src_req_o=0.
- Back-to-back: req_i=4'b0011, ack in WAIT for grant 0 → next cycle state=LOAD with gnt_idx_o=1, no IDLE cycle in between; src_data_o updates only while src_req_o=0.
- Timeout: TimeoutCycles=8, ack withheld → timeout_o=1 from the 9th WAIT cycle, src_req_o stays 1. Ack arrives → ack_o pulse and timeout_o=0 the next cycle.
- Reset mid-WAIT: rst_i=1 for 1 cycle during WAIT → all outputs 0 next cycle, no ack_o. A subsequent request on req_i=4'b1000 is granted to requester 3 (pointer reset).
- Spurious ack: src_ack_i=1 in IDLE and in LOAD → ack_o stays 0 and the state sequence is unchanged.
